// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter driving a shared 4:1 data mux.
// Each grant lasts until the owner withdraws or MAX_BURST beats transfer,
// and every grant is followed by exactly one idle cycle.
module mux_rr_arbiter #(
    parameter int unsigned W         = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic [W-1:0] a4,
    input  logic [3:0]   req,
    input  logic         ready,
    output logic [3:0]   gnt,
    output logic [1:0]   s,
    output logic [W-1:0] d,
    output logic         valid
);

    localparam int unsigned BEAT_W    = 4;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        s_q, s_d;
    logic [1:0]        last_q, last_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic       pick_found;
    logic [1:0] pick_idx;

    // Round-robin search: first requester at or above last+1, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int unsigned i = 1; i <= 4; i++) begin
            logic [1:0] cand;
            cand = last_q + 2'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state: claim in IDLE, release on withdrawal or final burst beat.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    s_d     = pick_idx;
                    last_d  = pick_idx;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (!req[s_q]) begin
                    state_d = IDLE;
                end else if (ready) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; last=3 makes requester 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 2'd0;
            last_q  <= 2'd3;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Grant decode, offer qualification and the shared data mux.
    always_comb begin
        gnt   = 4'b0000;
        valid = 1'b0;
        d     = '0;
        if (state_q == GRANT) begin
            gnt   = 4'b0001 << s_q;
            valid = req[s_q];
            case (s_q)
                2'd0:    d = a1;
                2'd1:    d = a2;
                2'd2:    d = a3;
                default: d = a4;
            endcase
        end
    end

    assign s = s_q;

endmodule
